// File: rtl/cpu_pipe_pkg.sv
// Shared types for the EX/MEM pipeline boundary: control bundle, skid-stage states, default widths.
// Pure declarations; no latency or backpressure of its own.
package cpu_pipe_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int REG_W_DEF  = 4;
  localparam int CTRL_W     = 6;

  // wbs: writeback select, mm: memory mode, wm: write memory, ni: no-increment, wme: writeback enable
  typedef struct packed {
    logic       wbs;
    logic [1:0] mm;
    logic       wm;
    logic       ni;
    logic       wme;
  } exmem_ctrl_t;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_HALF  = 2'd1,
    ST_FULL  = 2'd2
  } skid_state_e;

  function automatic logic [1:0] occ_of(input skid_state_e s);
    logic [1:0] occ;
    occ = 2'd0;
    case (s)
      ST_HALF: occ = 2'd1;
      ST_FULL: occ = 2'd2;
      default: occ = 2'd0;
    endcase
    return occ;
  endfunction

endpackage

// File: rtl/exmem_entry_reg.sv
// Load-enabled register for one EX/MEM bundle; zero-cleared on reset, holds value when not loaded.
// Latency one cycle from load to output; no flow control of its own.
module exmem_entry_reg
  import cpu_pipe_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int REG_W  = REG_W_DEF
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              load_i,
  input  exmem_ctrl_t       ctrl_i,
  input  logic [REG_W-1:0]  reg_dest_i,
  input  logic [DATA_W-1:0] alu_result_i,
  input  logic [DATA_W-1:0] mem_data_i,
  input  logic [DATA_W-1:0] wb_data_i,
  output exmem_ctrl_t       ctrl_o,
  output logic [REG_W-1:0]  reg_dest_o,
  output logic [DATA_W-1:0] alu_result_o,
  output logic [DATA_W-1:0] mem_data_o,
  output logic [DATA_W-1:0] wb_data_o
);

  exmem_ctrl_t       ctrl_q;
  logic [REG_W-1:0]  reg_dest_q;
  logic [DATA_W-1:0] alu_result_q;
  logic [DATA_W-1:0] mem_data_q;
  logic [DATA_W-1:0] wb_data_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      ctrl_q       <= '0;
      reg_dest_q   <= '0;
      alu_result_q <= '0;
      mem_data_q   <= '0;
      wb_data_q    <= '0;
    end else if (load_i) begin
      ctrl_q       <= ctrl_i;
      reg_dest_q   <= reg_dest_i;
      alu_result_q <= alu_result_i;
      mem_data_q   <= mem_data_i;
      wb_data_q    <= wb_data_i;
    end
  end

  assign ctrl_o       = ctrl_q;
  assign reg_dest_o   = reg_dest_q;
  assign alu_result_o = alu_result_q;
  assign mem_data_o   = mem_data_q;
  assign wb_data_o    = wb_data_q;

endmodule

// File: rtl/exmem_skid_stage.sv
// Two-entry EX/MEM skid buffer: one-cycle input-to-output latency, full throughput when unstalled.
// in_ready is registered (low only when both entries held), so out_ready never reaches it combinationally.
module exmem_skid_stage
  import cpu_pipe_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int REG_W  = REG_W_DEF,
  parameter int FWD_EN = 1
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  exmem_ctrl_t       in_ctrl_i,
  input  logic [REG_W-1:0]  in_reg_dest_i,
  input  logic [DATA_W-1:0] in_alu_result_i,
  input  logic [DATA_W-1:0] in_mem_data_i,
  input  logic [DATA_W-1:0] in_wb_data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output exmem_ctrl_t       out_ctrl_o,
  output logic [REG_W-1:0]  out_reg_dest_o,
  output logic [DATA_W-1:0] out_alu_result_o,
  output logic [DATA_W-1:0] out_mem_data_o,
  output logic [DATA_W-1:0] out_wb_data_o,
  output logic              fwd_valid_o,
  output logic [REG_W-1:0]  fwd_reg_o,
  output logic [DATA_W-1:0] fwd_data_o,
  output logic [1:0]        occupancy_o
);

  skid_state_e state_q, state_d;
  logic        in_ready_q;
  logic        in_xfer, out_xfer, out_valid;
  logic        main_ld, skid_ld, main_from_skid;

  exmem_ctrl_t       main_ctrl, skid_ctrl, main_src_ctrl;
  logic [REG_W-1:0]  main_reg_dest, skid_reg_dest, main_src_reg_dest;
  logic [DATA_W-1:0] main_alu, skid_alu, main_src_alu;
  logic [DATA_W-1:0] main_mem, skid_mem, main_src_mem;
  logic [DATA_W-1:0] main_wb, skid_wb, main_src_wb;

  assign out_valid = (state_q != ST_EMPTY);
  assign in_xfer   = in_valid_i && in_ready_q;
  assign out_xfer  = out_valid && out_ready_i;

  always_comb begin
    state_d        = state_q;
    main_ld        = 1'b0;
    skid_ld        = 1'b0;
    main_from_skid = 1'b0;
    // Flush wins over every transfer; entries keep their stale data so outputs stay deterministic.
    if (flush_i) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (in_xfer) begin
            main_ld = 1'b1;
            state_d = ST_HALF;
          end
        end
        ST_HALF: begin
          if (in_xfer && out_xfer) begin
            main_ld = 1'b1;
          end else if (in_xfer) begin
            skid_ld = 1'b1;
            state_d = ST_FULL;
          end else if (out_xfer) begin
            state_d = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (out_xfer) begin
            main_ld        = 1'b1;
            main_from_skid = 1'b1;
            state_d        = ST_HALF;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= ST_EMPTY;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      in_ready_q <= (state_d != ST_FULL);
    end
  end

  assign main_src_ctrl     = main_from_skid ? skid_ctrl     : in_ctrl_i;
  assign main_src_reg_dest = main_from_skid ? skid_reg_dest : in_reg_dest_i;
  assign main_src_alu      = main_from_skid ? skid_alu      : in_alu_result_i;
  assign main_src_mem      = main_from_skid ? skid_mem      : in_mem_data_i;
  assign main_src_wb       = main_from_skid ? skid_wb       : in_wb_data_i;

  exmem_entry_reg #(.DATA_W(DATA_W), .REG_W(REG_W)) u_main (
    .clk_i        (clk_i),
    .rst_n_i      (rst_n_i),
    .load_i       (main_ld),
    .ctrl_i       (main_src_ctrl),
    .reg_dest_i   (main_src_reg_dest),
    .alu_result_i (main_src_alu),
    .mem_data_i   (main_src_mem),
    .wb_data_i    (main_src_wb),
    .ctrl_o       (main_ctrl),
    .reg_dest_o   (main_reg_dest),
    .alu_result_o (main_alu),
    .mem_data_o   (main_mem),
    .wb_data_o    (main_wb)
  );

  exmem_entry_reg #(.DATA_W(DATA_W), .REG_W(REG_W)) u_skid (
    .clk_i        (clk_i),
    .rst_n_i      (rst_n_i),
    .load_i       (skid_ld),
    .ctrl_i       (in_ctrl_i),
    .reg_dest_i   (in_reg_dest_i),
    .alu_result_i (in_alu_result_i),
    .mem_data_i   (in_mem_data_i),
    .wb_data_i    (in_wb_data_i),
    .ctrl_o       (skid_ctrl),
    .reg_dest_o   (skid_reg_dest),
    .alu_result_o (skid_alu),
    .mem_data_o   (skid_mem),
    .wb_data_o    (skid_wb)
  );

  assign in_ready_o       = in_ready_q;
  assign out_valid_o      = out_valid;
  assign out_ctrl_o       = main_ctrl;
  assign out_reg_dest_o   = main_reg_dest;
  assign out_alu_result_o = main_alu;
  assign out_mem_data_o   = main_mem;
  assign out_wb_data_o    = main_wb;
  assign occupancy_o      = occ_of(state_q);

  // Register 0 is hardwired, so a write to it must never be bypassed.
  if (FWD_EN != 0) begin : g_fwd
    assign fwd_valid_o = out_valid && main_ctrl.wbs && (main_reg_dest != '0);
    assign fwd_reg_o   = main_reg_dest;
    assign fwd_data_o  = main_alu;
  end else begin : g_no_fwd
    assign fwd_valid_o = 1'b0;
    assign fwd_reg_o   = '0;
    assign fwd_data_o  = '0;
  end

endmodule

// File: tb/tb_exmem_skid_stage.sv
// Self-checking bench for exmem_skid_stage: directed scenarios plus random valid/ready traffic
// compared against a queue-based reference model of a two-deep in-order buffer.
module tb_exmem_skid_stage;
  import cpu_pipe_pkg::*;

  localparam int DW = 16;
  localparam int RW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  exmem_ctrl_t   in_ctrl;
  logic [RW-1:0] in_reg_dest;
  logic [DW-1:0] in_alu, in_mem, in_wb;
  logic          out_valid;
  logic          out_ready;
  exmem_ctrl_t   out_ctrl;
  logic [RW-1:0] out_reg_dest;
  logic [DW-1:0] out_alu, out_mem, out_wb;
  logic          fwd_valid;
  logic [RW-1:0] fwd_reg;
  logic [DW-1:0] fwd_data;
  logic [1:0]    occupancy;

  always #5 clk = ~clk;

  exmem_skid_stage #(.DATA_W(DW), .REG_W(RW), .FWD_EN(1)) dut (
    .clk_i            (clk),
    .rst_n_i          (rst_n),
    .flush_i          (flush),
    .in_valid_i       (in_valid),
    .in_ready_o       (in_ready),
    .in_ctrl_i        (in_ctrl),
    .in_reg_dest_i    (in_reg_dest),
    .in_alu_result_i  (in_alu),
    .in_mem_data_i    (in_mem),
    .in_wb_data_i     (in_wb),
    .out_valid_o      (out_valid),
    .out_ready_i      (out_ready),
    .out_ctrl_o       (out_ctrl),
    .out_reg_dest_o   (out_reg_dest),
    .out_alu_result_o (out_alu),
    .out_mem_data_o   (out_mem),
    .out_wb_data_o    (out_wb),
    .fwd_valid_o      (fwd_valid),
    .fwd_reg_o        (fwd_reg),
    .fwd_data_o       (fwd_data),
    .occupancy_o      (occupancy)
  );

  typedef struct {
    logic [5:0]    ctrl;
    logic [RW-1:0] rd;
    logic [DW-1:0] alu;
    logic [DW-1:0] mem;
    logic [DW-1:0] wb;
  } bundle_t;

  bundle_t q[$];
  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive(input logic v, input logic [5:0] c, input logic [RW-1:0] rd,
                       input logic [DW-1:0] alu, input logic [DW-1:0] mem, input logic [DW-1:0] wb);
    in_valid    = v;
    in_ctrl     = exmem_ctrl_t'(c);
    in_reg_dest = rd;
    in_alu      = alu;
    in_mem      = mem;
    in_wb       = wb;
  endtask

  // Reference: bounded FIFO of depth 2; acceptance is judged on the occupancy before the edge.
  task automatic model_edge();
    bundle_t b;
    bit      can_take, has_head;
    can_take = (q.size() < 2);
    has_head = (q.size() > 0);
    if (!rst_n || flush) begin
      q.delete();
    end else begin
      if (has_head && out_ready) void'(q.pop_front());
      if (in_valid && can_take) begin
        b.ctrl = in_ctrl;
        b.rd   = in_reg_dest;
        b.alu  = in_alu;
        b.mem  = in_mem;
        b.wb   = in_wb;
        q.push_back(b);
      end
    end
  endtask

  task automatic check_all();
    chk("out_valid", out_valid, q.size() > 0);
    chk("in_ready", in_ready, q.size() < 2);
    chk("occupancy", occupancy, q.size());
    if (q.size() > 0) begin
      chk("out_ctrl", out_ctrl, q[0].ctrl);
      chk("out_reg_dest", out_reg_dest, q[0].rd);
      chk("out_alu", out_alu, q[0].alu);
      chk("out_mem", out_mem, q[0].mem);
      chk("out_wb", out_wb, q[0].wb);
      chk("fwd_valid", fwd_valid, q[0].ctrl[5] && (q[0].rd != 0));
      if (q[0].ctrl[5] && (q[0].rd != 0)) begin
        chk("fwd_reg", fwd_reg, q[0].rd);
        chk("fwd_data", fwd_data, q[0].alu);
      end
    end else begin
      chk("fwd_valid_empty", fwd_valid, 1'b0);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all();
  endtask

  initial begin
    rst_n     = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b0;
    drive(1'b0, 6'h0, '0, '0, '0, '0);
    #12;
    @(negedge clk);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_occupancy", occupancy, 2'd0);
    chk("rst_fwd_valid", fwd_valid, 1'b0);
    chk("rst_out_alu", out_alu, 16'h0);
    rst_n = 1'b1;

    // Streaming at full rate
    out_ready = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      drive(1'b1, 6'h02, 4'd2, DW'(i), 16'hA000 + DW'(i), 16'hB000 + DW'(i));
      step();
      chk("stream_data", out_alu, i);
      chk("stream_in_ready", in_ready, 1'b1);
    end
    drive(1'b0, 6'h0, '0, '0, '0, '0);
    step();

    // Backpressure fills both entries, then drains in order
    out_ready = 1'b0;
    drive(1'b1, 6'h04, 4'd3, 16'h0050, 16'h1111, 16'h2222);
    step();
    drive(1'b1, 6'h08, 4'd4, 16'h0007, 16'h3333, 16'h4444);
    step();
    chk("bp_occupancy", occupancy, 2'd2);
    chk("bp_in_ready", in_ready, 1'b0);
    chk("bp_head", out_alu, 16'h0050);
    drive(1'b0, 6'h0, '0, '0, '0, '0);
    out_ready = 1'b1;
    step();
    chk("bp_second", out_alu, 16'h0007);
    step();
    chk("bp_drained", out_valid, 1'b0);

    // Flush while full with a pending input
    out_ready = 1'b0;
    drive(1'b1, 6'h0, 4'd5, 16'h0011, 16'h0, 16'h0);
    step();
    drive(1'b1, 6'h0, 4'd6, 16'h0022, 16'h0, 16'h0);
    step();
    drive(1'b1, 6'h0, 4'd7, 16'h0033, 16'h0, 16'h0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flush_out_valid", out_valid, 1'b0);
    chk("flush_occupancy", occupancy, 2'd0);
    chk("flush_in_ready", in_ready, 1'b1);
    drive(1'b0, 6'h0, '0, '0, '0, '0);
    out_ready = 1'b1;
    step();
    chk("flush_no_ghost", out_valid, 1'b0);

    // Flush in HALF discards the input accepted on that same edge
    out_ready = 1'b0;
    drive(1'b1, 6'h0, 4'd8, 16'h0044, 16'h0, 16'h0);
    step();
    drive(1'b1, 6'h0, 4'd9, 16'h0055, 16'h0, 16'h0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("flush_half_occ", occupancy, 2'd0);
    drive(1'b0, 6'h0, '0, '0, '0, '0);
    step();
    chk("flush_half_empty", out_valid, 1'b0);

    // Forwarding, including the reg 0 suppression
    drive(1'b1, 6'h20, 4'd1, 16'h0001, 16'h0, 16'h0);
    step();
    chk("fwd_valid_r1", fwd_valid, 1'b1);
    chk("fwd_reg_r1", fwd_reg, 4'd1);
    chk("fwd_data_r1", fwd_data, 16'h0001);
    out_ready = 1'b1;
    drive(1'b1, 6'h20, 4'd0, 16'h0009, 16'h0, 16'h0);
    step();
    chk("fwd_r0_passes", out_alu, 16'h0009);
    chk("fwd_r0_valid", out_valid, 1'b1);
    chk("fwd_valid_r0", fwd_valid, 1'b0);
    drive(1'b0, 6'h0, '0, '0, '0, '0);
    step();

    // Asynchronous reset mid-period while full
    out_ready = 1'b0;
    drive(1'b1, 6'h01, 4'd2, 16'h00AA, 16'h0, 16'h0);
    step();
    drive(1'b1, 6'h01, 4'd3, 16'h00BB, 16'h0, 16'h0);
    step();
    chk("pre_reset_occ", occupancy, 2'd2);
    drive(1'b0, 6'h0, '0, '0, '0, '0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", out_valid, 1'b0);
    chk("arst_in_ready", in_ready, 1'b1);
    chk("arst_occupancy", occupancy, 2'd0);
    chk("arst_fwd_valid", fwd_valid, 1'b0);
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    drive(1'b1, 6'h02, 4'd4, 16'h0066, 16'h0, 16'h0);
    step();
    chk("post_reset_data", out_alu, 16'h0066);
    chk("post_reset_occ", occupancy, 2'd1);
    drive(1'b0, 6'h0, '0, '0, '0, '0);
    step();

    // Random traffic against the reference model
    for (int c = 0; c < 10000; c++) begin
      drive($urandom_range(0, 3) != 0, 6'($urandom), RW'($urandom), DW'($urandom),
            DW'($urandom), DW'($urandom));
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 63) == 0);
      step();
    end
    flush = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
